hilo_unit: RTL and testbench
============================

HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 Parameter: XLEN, 32, operand and HI/LO register width; only 32 is supported.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request strobe; sampled only while busy=0.
REQ-005 op  input  5  operation code: MULT=00110, MULTU=00111, DIV=01000, DIVU=01001, MTHI=10010, MTLO=10011.
REQ-006 op1  input  32  rs operand (dividend / multiplicand / MTHI-MTLO source).
REQ-007 op2  input  32  rt operand (divisor / multiplier).
REQ-008 busy  output  1  iterative operation in progress; pipeline stalls MFHI/MFLO and new mult/div ops.
REQ-009 done  output  1  one-cycle pulse when a MULT/MULTU/DIV/DIVU completes or aborts on divide-by-zero.
REQ-010 hi  output  32  HI register, readable at all times (MFHI).
REQ-011 lo  output  32  LO register, readable at all times (MFLO).
REQ-012 divideZero  output  1  one-cycle pulse, coincident with done, for DIV/DIVU with op2=0.

Function
REQ-013 The FSM SHALL have the states IDLE, MUL, DIV and FINISH; busy=1 in every state except IDLE.
REQ-014 In IDLE, start with MULT/MULTU/DIV/DIVU SHALL latch op1, op2 and op, and SHALL enter MUL or DIV at that edge.
REQ-015 Later changes to op1/op2/op SHALL NOT affect an accepted operation.
REQ-016 start while busy=1 SHALL be ignored.
REQ-017 start with an unlisted op code SHALL be ignored.
REQ-018 MTHI/MTLO in IDLE SHALL write op1 to hi/lo at that edge, without busy and without done.
REQ-019 MUL: 32 radix-2 shift-add iterations on operand magnitudes (signed for MULT, raw for MULTU), one per clock.
REQ-020 FINISH SHALL negate the 64-bit product when MULT operand signs differ, then write hi=product[63:32] and lo=product[31:0].
REQ-021 DIV: 32 restoring-division iterations on magnitudes, one per clock.
REQ-022 FINISH SHALL write lo=quotient and hi=remainder.
REQ-023 DIV sign rules: quotient negative iff operand signs differ; remainder takes the sign of op1.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0, with no flag.
REQ-025 Latency SHALL be fixed at 34 clocks: accept edge N, iterations at edges N+1..N+32, sign fix at N+33, and hi/lo written at N+34.
REQ-026 done SHALL be high in the cycle after edge N+34, with return to IDLE.
REQ-027 DIV/DIVU with op2=0 SHALL skip the iterations and return to IDLE at edge N+1 with done=1 and divideZero=1 for one cycle.
REQ-028 On divide-by-zero, hi and lo SHALL remain unchanged.
REQ-029 done and divideZero SHALL never be high in the same cycle as an accepting start edge's busy=0 (no back-to-back overlap).
REQ-030 A new start is legal in the done cycle.

Reset
REQ-031 reset low SHALL immediately force state=IDLE, hi=0, lo=0, busy=0, done=0, divideZero=0, and clear all iteration registers.
REQ-032 reset mid-operation SHALL abort the operation without producing a done pulse.
REQ-033 After reset deasserts, operation SHALL resume at the next rising edge.

Configuration
REQ-034 Macro HILO_DIV_EN defined: DIV/DIVU SHALL behave as specified above.
REQ-035 HILO_DIV_EN undefined: the divider datapath and the DIV state SHALL be absent.
REQ-036 HILO_DIV_EN undefined: DIV/DIVU SHALL complete at edge N+1 with done=1, divideZero=0, and hi/lo unchanged.

Structure
REQ-037 The op encodings (shared with the ALU control field), XLEN and the FSM state enum SHALL live in the shared alu package.
REQ-038 The iteration step SHALL be a sub-module, hilo_div_step (one restoring-division step), instantiated only under HILO_DIV_EN.
REQ-039 The multiply step SHALL stay inline.

Verification
REQ-040 MULT op1=0xFFFFFFFE, op2=3 -> at N+34 hi=0xFFFFFFFF, lo=0xFFFFFFFA; done high exactly one cycle; busy high N..N+34.
REQ-041 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-042 DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-043 DIV op2=0 with hi=0xAAAA0000, lo=0x5555 -> next cycle done=divideZero=1, hi/lo unchanged; without HILO_DIV_EN, divideZero=0.
REQ-044 MTHI 0x12345678 in IDLE -> hi=0x12345678 at next edge, busy stays 0; MTLO or MULT start during busy -> ignored, result unchanged.
REQ-045 reset low at iteration 10 of a DIV -> hi=lo=0 immediately, busy=0, no done pulse; a following MULTU 2x3 -> lo=6 after 34 clocks.

Source files
------------

// File: rtl/hilo_unit_pkg.sv
// hilo_unit_pkg: op encodings shared with the ALU control field, XLEN and HI/LO FSM states.
// The DIV state exists only when HILO_DIV_EN is defined.
package hilo_unit_pkg;
  localparam int XLEN = 32;
  typedef enum logic [4:0] {
    OP_MULT  = 5'b00110,
    OP_MULTU = 5'b00111,
    OP_DIV   = 5'b01000,
    OP_DIVU  = 5'b01001,
    OP_MTHI  = 5'b10010,
    OP_MTLO  = 5'b10011
  } op_e;
`ifdef HILO_DIV_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FINISH} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_FINISH} state_e;
`endif
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? -v : v;
  endfunction
endpackage

// File: rtl/hilo_unit_div_step.sv
// hilo_div_step: one restoring-division step on unsigned magnitudes.
module hilo_div_step
  import hilo_unit_pkg::*;
(
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_div,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo
);
  logic [XLEN:0] w_sh, w_diff;
  assign w_sh   = {i_rem, i_quo[XLEN-1]};
  assign w_diff = w_sh - {1'b0, i_div};
  assign o_rem  = w_diff[XLEN] ? w_sh[XLEN-1:0] : w_diff[XLEN-1:0];
  assign o_quo  = {i_quo[XLEN-2:0], ~w_diff[XLEN]};
endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: MIPS HI/LO unit with iterative multiply and (under HILO_DIV_EN) restoring divide.
// Without HILO_DIV_EN, DIV/DIVU complete in one cycle leaving HI/LO untouched.
module hilo_unit
  import hilo_unit_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [4:0]      i_op,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo,
  output logic            o_divide_zero
);
  state_e            r_state;
  logic [XLEN-1:0]   r_hi, r_lo, r_a;
  logic [2*XLEN-1:0] r_res;
  logic [4:0]        r_cnt;
  logic              r_phase, r_neg_q, r_done, r_dz;
  logic              w_mul, w_div, w_sgn;
  logic [XLEN:0]     w_sum;
  assign w_mul  = i_op == OP_MULT || i_op == OP_MULTU;
  assign w_div  = i_op == OP_DIV || i_op == OP_DIVU;
  assign w_sgn  = ~i_op[0];
  assign w_sum  = {1'b0, r_res[2*XLEN-1:XLEN]} + {1'b0, r_res[0] ? r_a : {XLEN{1'b0}}};
  assign o_busy = r_state != S_IDLE;
  assign o_done = r_done;
  assign o_divide_zero = r_dz;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
`ifdef HILO_DIV_EN
  logic            r_neg_r, r_is_div;
  logic [XLEN-1:0] w_rem, w_quo;
  hilo_div_step u_step (
    .i_rem(r_res[2*XLEN-1:XLEN]),
    .i_quo(r_res[XLEN-1:0]),
    .i_div(r_a),
    .o_rem(w_rem),
    .o_quo(w_quo)
  );
`endif
  // r_res holds {acc, multiplier} while multiplying and {remainder, quotient} while dividing
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_a     <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_neg_q <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
`ifdef HILO_DIV_EN
      r_neg_r  <= 1'b0;
      r_is_div <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          if (i_op == OP_MTHI) r_hi <= i_op1;
          if (i_op == OP_MTLO) r_lo <= i_op1;
          if (w_mul) begin
            r_state <= S_MUL;
            r_a     <= mag(i_op1, w_sgn);
            r_res   <= {{XLEN{1'b0}}, mag(i_op2, w_sgn)};
            r_neg_q <= w_sgn & (i_op1[XLEN-1] ^ i_op2[XLEN-1]);
            r_cnt   <= '0;
            r_phase <= 1'b0;
`ifdef HILO_DIV_EN
            r_is_div <= 1'b0;
`endif
          end
          if (w_div) begin
`ifdef HILO_DIV_EN
            r_state  <= S_DIV;
            r_a      <= mag(i_op2, w_sgn);
            r_res    <= {{XLEN{1'b0}}, mag(i_op1, w_sgn)};
            r_neg_q  <= w_sgn & (i_op1[XLEN-1] ^ i_op2[XLEN-1]);
            r_neg_r  <= w_sgn & i_op1[XLEN-1];
            r_is_div <= 1'b1;
            r_cnt    <= '0;
            r_phase  <= 1'b0;
`else
            r_state <= S_FINISH;
            r_res   <= {r_hi, r_lo};
            r_phase <= 1'b1;
`endif
          end
        end
        S_MUL: begin
          r_res <= {w_sum, r_res[XLEN-1:1]};
          r_cnt <= r_cnt + 5'd1;
          if (&r_cnt) r_state <= S_FINISH;
        end
`ifdef HILO_DIV_EN
        S_DIV: if (r_a == '0) begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
          r_dz    <= 1'b1;
        end else begin
          r_res <= {w_rem, w_quo};
          r_cnt <= r_cnt + 5'd1;
          if (&r_cnt) r_state <= S_FINISH;
        end
`endif
        S_FINISH: if (!r_phase) begin
          r_phase <= 1'b1;
`ifdef HILO_DIV_EN
          if (r_is_div)
            r_res <= {r_neg_r ? -r_res[2*XLEN-1:XLEN] : r_res[2*XLEN-1:XLEN],
                      r_neg_q ? -r_res[XLEN-1:0] : r_res[XLEN-1:0]};
          else
            r_res <= r_neg_q ? -r_res : r_res;
`else
          r_res <= r_neg_q ? -r_res : r_res;
`endif
        end else begin
          r_hi    <= r_res[2*XLEN-1:XLEN];
          r_lo    <= r_res[XLEN-1:0];
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: randomized scoreboard bench for hilo_unit against an arithmetic reference model.
// Honours HILO_DIV_EN the same way the design does.
module tb_hilo_unit;
  import hilo_unit_pkg::*;
  logic        clk = 0, rst_n = 0, start = 0;
  logic [4:0]  op = 0;
  logic [31:0] op1 = 0, op2 = 0;
  logic        busy, done, dz;
  logic [31:0] hi, lo;
  typedef struct {
    logic [31:0] hi, lo;
    logic        dz;
    int          acc, lat;
  } exp_t;
  exp_t        q[$];
  exp_t        got;
  int          vectors = 0, errs = 0, cyc = 0;
  logic [31:0] m_hi = 0, m_lo = 0;

  hilo_unit dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op), .i_op1(op1), .i_op2(op2),
    .o_busy(busy), .o_done(done), .o_hi(hi), .o_lo(lo), .o_divide_zero(dz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) if (rst_n) begin
    if (dz) check("dz_with_done", 64'(done), 64'd1);
    if (done) begin
      check("done_pending", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        got = q.pop_front();
        check("hi", 64'(hi), 64'(got.hi));
        check("lo", 64'(lo), 64'(got.lo));
        check("dz", 64'(dz), 64'(got.dz));
        check("latency", 64'(cyc - got.acc), 64'(got.lat));
      end
    end
  end

  function automatic logic [4:0] rop();
    case ($urandom_range(0, 7))
      0: return OP_MULT;
      1: return OP_MULTU;
      2: return OP_DIV;
      3: return OP_DIVU;
      4: return OP_MTHI;
      5: return OP_MTLO;
      6: return 5'b11111;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic [31:0] rval();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    longint      sa, sb;
    bit          md;
    int          n;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.hi = m_hi; e.lo = m_lo; e.dz = 0; e.lat = 34; e.acc = 0; md = 1;
    case (o)
      OP_MULT:  begin p = 64'(sa * sb); {e.hi, e.lo} = p; end
      OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; {e.hi, e.lo} = p; end
      OP_DIV, OP_DIVU: begin
`ifdef HILO_DIV_EN
        if (b == 0) begin e.dz = 1; e.lat = 1; end
        else if (o == OP_DIV) begin e.lo = 32'(sa / sb); e.hi = 32'(sa % sb); end
        else begin e.lo = a / b; e.hi = a % b; end
`else
        e.lat = 1;
`endif
      end
      default: md = 0;
    endcase
    start = 1; op = o; op1 = a; op2 = b;
    @(posedge clk); #1;
    e.acc = cyc;
    start = 0; op = rop(); op1 = $urandom; op2 = $urandom;
    if (md) begin
      q.push_back(e);
      m_hi = e.hi; m_lo = e.lo;
      n = 0;
      @(negedge clk);
      while (busy && n < 40) begin
        n++;
        start = 1'($urandom_range(0, 1)); op = rop(); op1 = rval(); op2 = rval();
        @(negedge clk);
      end
      start = 0;
      check("busy_cycles", 64'(n), 64'(e.lat));
    end else begin
      if (o == OP_MTHI) m_hi = a;
      if (o == OP_MTLO) m_lo = a;
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_hi", 64'(hi), 64'(m_hi));
      check("idle_lo", 64'(lo), 64'(m_lo));
      @(negedge clk);
    end
  endtask

  initial begin
    #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(dz), 64'd0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    issue(OP_MULT, 32'hFFFFFFFE, 32'd3);
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    issue(OP_DIVU, 32'd7, 32'd2);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    issue(OP_MTHI, 32'hAAAA0000, 32'd0);
    issue(OP_MTLO, 32'h00005555, 32'd0);
    issue(OP_DIV, 32'd123, 32'd0);
    issue(OP_DIVU, 32'd9, 32'd0);
    issue(OP_MTHI, 32'h12345678, 32'd0);
    issue(5'b11111, 32'hDEADBEEF, 32'd1);
    // Abort a long operation with reset; no done may follow.
    start = 1;
`ifdef HILO_DIV_EN
    op = OP_DIV;
`else
    op = OP_MULT;
`endif
    op1 = 32'd1000; op2 = 32'd7;
    @(posedge clk); #1; start = 0;
    repeat (10) @(negedge clk);
    rst_n = 0; #1;
    q.delete(); m_hi = 0; m_lo = 0;
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    issue(OP_MULTU, 32'd2, 32'd3);
    for (int i = 0; i < 80; i++) issue(rop(), rval(), rval());
    repeat (5) @(negedge clk);
    check("queue_empty", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
